// File: rtl/button_bank_if.sv
// Button bank signal bundle: raw inputs in, conditioned levels and pulses out.
// slave = conditioner side, master = driver/consumer side.
interface button_bank_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;
    logic [N_BTN-1:0] btn_event;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat,
        input  btn_event
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat,
        output btn_event
    );
endinterface

// File: rtl/button_bank.sv
// N-channel push-button conditioner: sync, shared-tick debounce, edge pulses.
// Auto-repeat hold counters are built only when BTN_AUTOREPEAT_EN is defined.
module button_bank #(
    parameter int N_BTN        = 5,
    parameter int CLK_DIV      = 100000,
    parameter int DEB_SAMPLES  = 4,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic          clk,
    input  logic          rst,
    button_bank_if.slave  bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int DEB_W = $clog2(DEB_SAMPLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_SAMPLES - 1);

    if (CLK_DIV < 2 || DEB_SAMPLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
    begin : g_bad_param
        $error("button_bank: parameter out of range");
    end

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DEB_W-1:0] r_deb_cnt [N_BTN];
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;
    logic [N_BTN-1:0] r_repeat;
    logic [N_BTN-1:0] r_event;

    logic             w_tick;
    logic [N_BTN-1:0] w_flip;
    logic [N_BTN-1:0] w_rep;

    // Two-flop synchroniser on every raw input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Shared prescaler producing the sample tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Level flips when the last of the required differing samples arrives
    always_comb begin
        w_tick = (r_div_cnt == DIV_LAST);
        w_flip = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_flip[i] = w_tick
                     && (r_sync2[i] != r_level[i])
                     && (r_deb_cnt[i] == DEB_LAST);
        end
    end

    // Per-channel debounce counters; any agreeing sample restarts the count
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BTN; i++) begin
            if (rst) begin
                r_deb_cnt[i] <= '0;
            end else if (w_tick) begin
                if (r_sync2[i] == r_level[i] || w_flip[i]) begin
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ?
                              REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] DLY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST = HOLD_W'(REPEAT_RATE - 1);

    logic [HOLD_W-1:0] r_hold [N_BTN];
    logic [N_BTN-1:0]  r_armed;

    // Repeat fires on a tick while held; first after the delay, then per rate
    always_comb begin
        w_rep = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_rep[i] = w_tick && r_level[i] && !w_flip[i]
                    && (r_armed[i] ? (r_hold[i] == RATE_LAST)
                                   : (r_hold[i] == DLY_LAST));
        end
    end

    // Hold counters: idle at 0 while released, restart after every repeat
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BTN; i++) begin
            if (rst || !r_level[i] || w_flip[i]) begin
                r_hold[i]  <= '0;
                r_armed[i] <= 1'b0;
            end else if (w_rep[i]) begin
                r_hold[i]  <= '0;
                r_armed[i] <= 1'b1;
            end else if (w_tick) begin
                r_hold[i]  <= r_hold[i] + HOLD_W'(1);
            end
        end
    end
`else
    assign w_rep = '0;
`endif

    // Registered level and one-cycle pulses, all updated on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_repeat  <= '0;
            r_event   <= '0;
        end else begin
            r_level   <= r_level ^ w_flip;
            r_press   <= w_flip & ~r_level;
            r_release <= w_flip & r_level;
            r_repeat  <= w_rep;
            r_event   <= (w_flip & ~r_level) | w_rep;
        end
    end

    assign bus.btn_level   = r_level;
    assign bus.btn_press   = r_press;
    assign bus.btn_release = r_release;
    assign bus.btn_repeat  = r_repeat;
    assign bus.btn_event   = r_event;
endmodule

// File: tb/tb_button_bank.sv
// Self-checking bench for button_bank with a tick/sample-count reference model.
// Honours BTN_AUTOREPEAT_EN in its expectations.
module tb_button_bank;
    localparam int N  = 5;
    localparam int CD = 4;
    localparam int DS = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] raw = '0;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    button_bank_if #(.N_BTN(N)) bus ();
    assign bus.btn_raw = raw;

    button_bank #(
        .N_BTN(N), .CLK_DIV(CD), .DEB_SAMPLES(DS),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model: tick = every CD-th cycle since reset, level flips after
    // DS consecutive differing tick samples, repeats from ticks held since press.
    logic [N-1:0] m_s1, m_s2, m_lvl, e_press, e_rel, e_rep, e_evt;
    int m_cyc;
    int m_diff [N];
    int m_held [N];

    always @(posedge clk) begin : model
        bit tick;
        bit flip;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_cyc = 0;
            e_press = '0; e_rel = '0; e_rep = '0; e_evt = '0;
            for (int i = 0; i < N; i++) begin
                m_diff[i] = 0;
                m_held[i] = 0;
            end
        end else begin
            tick = ((m_cyc % CD) == CD - 1);
            m_cyc++;
            e_press = '0; e_rel = '0; e_rep = '0;
            for (int i = 0; i < N; i++) begin
                flip = 1'b0;
                if (tick) begin
                    if (m_s2[i] == m_lvl[i]) m_diff[i] = 0;
                    else begin
                        m_diff[i]++;
                        if (m_diff[i] == DS) begin
                            flip = 1'b1;
                            m_diff[i] = 0;
                        end
                    end
                end
                if (flip && !m_lvl[i]) begin
                    e_press[i] = 1'b1; m_lvl[i] = 1'b1; m_held[i] = 0;
                end else if (flip) begin
                    e_rel[i] = 1'b1; m_lvl[i] = 1'b0; m_held[i] = 0;
                end else if (m_lvl[i] && tick) begin
                    m_held[i]++;
`ifdef BTN_AUTOREPEAT_EN
                    if (m_held[i] == RD ||
                        (m_held[i] > RD && (m_held[i] - RD) % RR == 0))
                        e_rep[i] = 1'b1;
`endif
                end
            end
            e_evt = e_press | e_rep;
            m_s2 = m_s1;
            m_s1 = raw;
        end
    end

    task automatic test_reset;
        int presses = 0;
        raw = '1;
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release,
                 bus.btn_repeat, bus.btn_event} !== 25'd0) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d got=%h want=0", c,
                    {bus.btn_level, bus.btn_press, bus.btn_release,
                     bus.btn_repeat, bus.btn_event});
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            n_chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release,
                 bus.btn_repeat, bus.btn_event} !==
                {m_lvl, e_press, e_rel, e_rep, e_evt}) begin
                n_fail++;
                $display("FAIL reset_model c=%0d got=%h want=%h", c,
                    {bus.btn_level, bus.btn_press, bus.btn_release,
                     bus.btn_repeat, bus.btn_event},
                    {m_lvl, e_press, e_rel, e_rep, e_evt});
            end
            if (bus.btn_press == 5'b11111) presses++;
        end
        n_chk++;
        if (presses != 1 || bus.btn_level !== 5'b11111) begin
            n_fail++;
            $display("FAIL reset_release presses=%0d level=%b want 1/11111",
                presses, bus.btn_level);
        end
        raw = '0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            n_chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release,
                 bus.btn_repeat, bus.btn_event} !==
                {m_lvl, e_press, e_rel, e_rep, e_evt}) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d got=%h want=%h", c,
                    {bus.btn_level, bus.btn_press, bus.btn_release,
                     bus.btn_repeat, bus.btn_event},
                    {m_lvl, e_press, e_rel, e_rep, e_evt});
            end
        end
    endtask

    task automatic test_press_ch0;
        int presses = 0;
        int releases = 0;
        int rise_c = -1;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        for (int c = 0; c < 70; c++) begin
            raw[0] = (c < 40);
            @(negedge clk);
            n_chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release,
                 bus.btn_repeat, bus.btn_event} !==
                {m_lvl, e_press, e_rel, e_rep, e_evt}) begin
                n_fail++;
                $display("FAIL press_ch0 c=%0d got=%h want=%h", c,
                    {bus.btn_level, bus.btn_press, bus.btn_release,
                     bus.btn_repeat, bus.btn_event},
                    {m_lvl, e_press, e_rel, e_rep, e_evt});
            end
            if (bus.btn_press[0]) presses++;
            if (bus.btn_release[0]) releases++;
            if (bus.btn_level[0] && rise_c < 0) rise_c = c;
        end
        n_chk++;
        if (presses != 1 || releases != 1) begin
            n_fail++;
            $display("FAIL press_ch0_pulses press=%0d rel=%0d want 1/1",
                presses, releases);
        end
        n_chk++;
        if (rise_c < 10 || rise_c > 13) begin
            n_fail++;
            $display("FAIL press_ch0_latency rise=%0d want 10..13", rise_c);
        end
    endtask

    task automatic test_bounce_ch1;
        int pulses = 0;
        for (int c = 0; c < 64; c++) begin
            raw[1] = (c < 48) ? (((c / 4) % 2) == 0) : 1'b0;
            @(negedge clk);
            n_chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release,
                 bus.btn_repeat, bus.btn_event} !==
                {m_lvl, e_press, e_rel, e_rep, e_evt}) begin
                n_fail++;
                $display("FAIL bounce_ch1 c=%0d got=%h want=%h", c,
                    {bus.btn_level, bus.btn_press, bus.btn_release,
                     bus.btn_repeat, bus.btn_event},
                    {m_lvl, e_press, e_rel, e_rep, e_evt});
            end
            if (bus.btn_level[1] || bus.btn_press[1] || bus.btn_release[1])
                pulses++;
        end
        n_chk++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL bounce_ch1_quiet active=%0d want 0", pulses);
        end
    endtask

    task automatic test_simultaneous;
        int good = 0;
        int bad = 0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        for (int c = 0; c < 60; c++) begin
            raw = (c < 30) ? 5'b10001 : 5'b00000;
            @(negedge clk);
            n_chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release,
                 bus.btn_repeat, bus.btn_event} !==
                {m_lvl, e_press, e_rel, e_rep, e_evt}) begin
                n_fail++;
                $display("FAIL simult c=%0d got=%h want=%h", c,
                    {bus.btn_level, bus.btn_press, bus.btn_release,
                     bus.btn_repeat, bus.btn_event},
                    {m_lvl, e_press, e_rel, e_rep, e_evt});
            end
            if (bus.btn_press == 5'b10001) good++;
            else if (bus.btn_press != 5'b00000) bad++;
        end
        n_chk++;
        if (good != 1 || bad != 0) begin
            n_fail++;
            $display("FAIL simult_press good=%0d bad=%0d want 1/0", good, bad);
        end
    endtask

    task automatic test_repeat_ch2;
        int reps = 0;
        int evts = 0;
        int late = 0;
        int rels = 0;
        for (int c = 0; c < 100; c++) begin
            raw[2] = (c < 60);
            @(negedge clk);
            n_chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release,
                 bus.btn_repeat, bus.btn_event} !==
                {m_lvl, e_press, e_rel, e_rep, e_evt}) begin
                n_fail++;
                $display("FAIL repeat_ch2 c=%0d got=%h want=%h", c,
                    {bus.btn_level, bus.btn_press, bus.btn_release,
                     bus.btn_repeat, bus.btn_event},
                    {m_lvl, e_press, e_rel, e_rep, e_evt});
            end
            if (c < 60 && bus.btn_repeat[2]) reps++;
            if (c < 60 && bus.btn_event[2]) evts++;
            if (rels > 0 && bus.btn_repeat[2]) late++;
            if (bus.btn_release[2]) rels++;
        end
`ifdef BTN_AUTOREPEAT_EN
        n_chk++;
        if (reps != 4 || evts != 5) begin
            n_fail++;
            $display("FAIL repeat_count reps=%0d evts=%0d want 4/5", reps, evts);
        end
`else
        n_chk++;
        if (reps != 0 || evts != 1) begin
            n_fail++;
            $display("FAIL repeat_off reps=%0d evts=%0d want 0/1", reps, evts);
        end
`endif
        n_chk++;
        if (late != 0 || rels != 1) begin
            n_fail++;
            $display("FAIL repeat_release late=%0d rels=%0d want 0/1",
                late, rels);
        end
    endtask

    task automatic test_reset_mid_hold_ch3;
        int presses = 0;
        int rels = 0;
        raw[3] = 1'b1;
        repeat (30) @(negedge clk);
        n_chk++;
        if (bus.btn_level[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre level3=%b want 1", bus.btn_level[3]);
        end
        for (int c = 0; c < 40; c++) begin
            rst = (c < 3);
            @(negedge clk);
            n_chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release,
                 bus.btn_repeat, bus.btn_event} !==
                {m_lvl, e_press, e_rel, e_rep, e_evt}) begin
                n_fail++;
                $display("FAIL midrst c=%0d got=%h want=%h", c,
                    {bus.btn_level, bus.btn_press, bus.btn_release,
                     bus.btn_repeat, bus.btn_event},
                    {m_lvl, e_press, e_rel, e_rep, e_evt});
            end
            if (bus.btn_press[3]) presses++;
            if (bus.btn_release[3]) rels++;
        end
        n_chk++;
        if (presses != 1 || rels != 0 || bus.btn_level[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_repress press=%0d rel=%0d lvl=%b want 1/0/1",
                presses, rels, bus.btn_level[3]);
        end
        raw[3] = 1'b0;
        repeat (24) @(negedge clk);
    endtask

    task automatic test_random;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) == 0) raw[i] = ~raw[i];
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            n_chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release,
                 bus.btn_repeat, bus.btn_event} !==
                {m_lvl, e_press, e_rel, e_rep, e_evt}) begin
                n_fail++;
                $display("FAIL random c=%0d got=%h want=%h", c,
                    {bus.btn_level, bus.btn_press, bus.btn_release,
                     bus.btn_repeat, bus.btn_event},
                    {m_lvl, e_press, e_rel, e_rep, e_evt});
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press_ch0();
        test_bounce_ch1();
        test_simultaneous();
        test_repeat_ch2();
        test_reset_mid_hold_ch3();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_chk, n_fail);
        $finish;
    end
endmodule
